// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse generator: FSM states,
// phase-counter width and the high/low timing pair.
package pulse_gen_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] low;
    } pulse_cfg_t;

    // Entry state for a freshly loaded timing; an all-zero timing is rejected.
    function automatic state_e first_state(input pulse_cfg_t c);
        if (c.high != '0) begin
            return HIGH;
        end else if (c.low != '0) begin
            return LOW;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/pulse_cfg_stage.sv
// One-entry pending register for pulse timing with a valid/ready offer port
// and a take strobe from the generator that consumes the held entry.
module pulse_cfg_stage
    import pulse_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic             take,
    output logic             pend_valid,
    output pulse_cfg_t       pend_cfg
);

    logic       ready_q, ready_d;
    logic       valid_q, valid_d;
    pulse_cfg_t cfg_q, cfg_d;
    logic       accept;

    always_comb begin
        accept  = cfg_valid && ready_q;
        valid_d = valid_q;
        cfg_d   = cfg_q;
        if (take) begin
            valid_d = 1'b0;
        end
        // A same-edge accept wins: the old entry is taken, the new one is held.
        if (accept) begin
            valid_d     = 1'b1;
            cfg_d.high  = cfg_high;
            cfg_d.low   = cfg_low;
        end
        // Falls on the accepting edge; rises one edge after the slot empties,
        // i.e. together with the first cycle of the newly loaded timing.
        ready_d = !valid_d && !valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            cfg_q   <= '0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
            cfg_q   <= cfg_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign pend_valid = valid_q;
    assign pend_cfg   = cfg_q;

endmodule

// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: IDLE/HIGH/LOW FSM with an 8-bit phase
// counter, timing reloaded from a pending slot at period boundaries.
module pulse_gen
    import pulse_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    output logic             trigger,
    output logic             period_done,
    output logic [CNT_W-1:0] active_high
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pulse_cfg_t       act_q, act_d;
    logic             trigger_q, trigger_d;
    logic             period_done_q, period_done_d;
    logic [CNT_W-1:0] active_high_q, active_high_d;

    logic             pend_valid;
    pulse_cfg_t       pend_cfg;
    pulse_cfg_t       load_cfg;
    logic             take;
    logic             load;
    logic             last_high;
    logic             last_low;
    logic             period_end;

    pulse_cfg_stage u_cfg (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_high   (cfg_high),
        .cfg_low    (cfg_low),
        .take       (take),
        .pend_valid (pend_valid),
        .pend_cfg   (pend_cfg)
    );

    always_comb begin
        last_high  = (state_q == HIGH) && (cnt_q == act_q.high - CNT_W'(1));
        last_low   = (state_q == LOW)  && (cnt_q == act_q.low  - CNT_W'(1));
        period_end = (last_high && (act_q.low == '0)) || last_low;

        state_d  = state_q;
        cnt_d    = cnt_q;
        act_d    = act_q;
        take     = 1'b0;
        load     = 1'b0;
        load_cfg = act_q;

        case (state_q)
            IDLE: begin
                if (en && pend_valid) begin
                    take     = 1'b1;
                    load     = 1'b1;
                    load_cfg = pend_cfg;
                end
            end
            HIGH: begin
                if (!last_high) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (act_q.low != '0) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (!last_low) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (period_end) begin
            if (!en) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                load = 1'b1;
                if (pend_valid) begin
                    take     = 1'b1;
                    load_cfg = pend_cfg;
                end
            end
        end

        if (load) begin
            state_d = first_state(load_cfg);
            cnt_d   = '0;
            act_d   = (state_d == IDLE) ? '0 : load_cfg;
        end

        // Outputs follow the state by one edge, so a load on leaving IDLE
        // shows on trigger two edges after the accepting edge.
        trigger_d     = (state_q == HIGH);
        period_done_d = period_end;
        active_high_d = (state_q == IDLE) ? '0 : act_q.high;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            act_q         <= '0;
            trigger_q     <= 1'b0;
            period_done_q <= 1'b0;
            active_high_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            act_q         <= act_d;
            trigger_q     <= trigger_d;
            period_done_q <= period_done_d;
            active_high_q <= active_high_d;
        end
    end

    assign trigger     = trigger_q;
    assign period_done = period_done_q;
    assign active_high = active_high_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Self-checking bench for pulse_gen: expected trigger/period_done samples are
// queued per scenario and popped once per cycle on the falling clock edge.
module tb_pulse_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_high;
    logic [7:0] cfg_low;
    logic       trigger;
    logic       period_done;
    logic [7:0] active_high;

    logic [1:0] q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    pulse_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
        .trigger     (trigger),
        .period_done (period_done),
        .active_high (active_high)
    );

    always #5 clk = ~clk;

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) q.push_back(2'b00);
    endtask

    task automatic push_period(input int h, input int l);
        for (int k = 0; k < h + l; k++)
            q.push_back({(k < h) ? 1'b1 : 1'b0, (k == h + l - 1) ? 1'b1 : 1'b0});
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Offer at a falling edge; returns at the falling edge after acceptance.
    task automatic offer(input logic [7:0] h, input logic [7:0] l);
        cfg_high = h; cfg_low = l; cfg_valid = 1'b1;
        for (int t = 0; t < 20 && cfg_ready !== 1'b1; t++) @(negedge clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL offer_ready: got %b want 1", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_high = '0; cfg_low = '0;
        @(negedge clk);
        n_cmp++;
        if ({trigger, period_done, active_high, cfg_ready} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {trigger, period_done, active_high, cfg_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready_before_edge: got %b want 0", cfg_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready_after_edge: got %b want 1", cfg_ready);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [1:0] e;
        en = 1'b1;
        offer(8'd3, 8'd5);
        push_idle(2);
        for (int p = 0; p < 3; p++) push_period(3, 5);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            n_cmp++;
            if ({trigger, period_done} !== e) begin
                n_err++;
                $display("FAIL basic[%0d] trig/pd: got %b want %b", i, {trigger, period_done}, e);
            end
            if (i == 1) begin
                n_cmp++;
                if (cfg_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_ready_idx1: got %b want 0", cfg_ready);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if ({cfg_ready, active_high} !== {1'b1, 8'd3}) begin
                    n_err++;
                    $display("FAIL basic_ready_ah_idx2: got %b/%0d want 1/3", cfg_ready, active_high);
                end
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_reconfig();
        int n;
        logic [1:0] e;
        en = 1'b1;
        offer(8'd4, 8'd4);
        push_idle(2);
        push_period(4, 4); push_period(4, 4);
        push_period(2, 2); push_period(9, 9);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            n_cmp++;
            if ({trigger, period_done} !== e) begin
                n_err++;
                $display("FAIL reconfig[%0d] trig/pd: got %b want %b", i, {trigger, period_done}, e);
            end
            if (i == 13 || i == 17 || i == 19) begin
                n_cmp++;
                if (cfg_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL reconfig_ready[%0d]: got %b want 0", i, cfg_ready);
                end
            end
            if (i == 18) begin
                n_cmp++;
                if ({cfg_ready, active_high} !== {1'b1, 8'd2}) begin
                    n_err++;
                    $display("FAIL reconfig_ready_ah[18]: got %b/%0d want 1/2", cfg_ready, active_high);
                end
            end
            if (i == 22) begin
                n_cmp++;
                if (active_high !== 8'd9) begin
                    n_err++;
                    $display("FAIL reconfig_ah[22]: got %0d want 9", active_high);
                end
            end
            if (i == 12) begin cfg_high = 8'd2; cfg_low = 8'd2; cfg_valid = 1'b1; end
            if (i == 13) begin cfg_high = 8'd9; cfg_low = 8'd9; end
            if (i == 19) cfg_valid = 1'b0;
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_degenerate();
        int n;
        logic [1:0] e;
        en = 1'b1;
        offer(8'd0, 8'd6);
        push_idle(2);
        push_period(0, 6); push_period(0, 6);
        push_period(7, 0); push_period(7, 0);
        push_idle(6);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            n_cmp++;
            if ({trigger, period_done} !== e) begin
                n_err++;
                $display("FAIL degen[%0d] trig/pd: got %b want %b", i, {trigger, period_done}, e);
            end
            if (i == 10 || i == 24) begin
                n_cmp++;
                if (cfg_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL degen_accept[%0d]: got %b want 0", i, cfg_ready);
                end
            end
            if (i == 29) begin
                n_cmp++;
                if ({cfg_ready, active_high} !== {1'b1, 8'd0}) begin
                    n_err++;
                    $display("FAIL degen_idle[29]: got %b/%0d want 1/0", cfg_ready, active_high);
                end
            end
            if (i == 9)  begin cfg_high = 8'd7; cfg_low = 8'd0; cfg_valid = 1'b1; end
            if (i == 23) begin cfg_high = 8'd0; cfg_low = 8'd0; cfg_valid = 1'b1; end
            if (i == 10 || i == 24) cfg_valid = 1'b0;
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_en_drop();
        int n;
        logic [1:0] e;
        en = 1'b1;
        offer(8'd5, 8'd5);
        push_idle(2);
        push_period(5, 5);
        push_idle(4);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            n_cmp++;
            if ({trigger, period_done} !== e) begin
                n_err++;
                $display("FAIL en_drop[%0d] trig/pd: got %b want %b", i, {trigger, period_done}, e);
            end
            if (i == 13) begin
                n_cmp++;
                if (active_high !== 8'd0) begin
                    n_err++;
                    $display("FAIL en_drop_ah[13]: got %0d want 0", active_high);
                end
            end
            if (i == 3) en = 1'b0;
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_long();
        int n;
        logic [1:0] e;
        en = 1'b1;
        offer(8'd255, 8'd1);
        push_idle(2);
        push_period(255, 1);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            n_cmp++;
            if ({trigger, period_done} !== e) begin
                n_err++;
                $display("FAIL long[%0d] trig/pd: got %b want %b", i, {trigger, period_done}, e);
            end
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_rst_mid();
        int n;
        logic [1:0] e;
        en = 1'b1;
        offer(8'd255, 8'd5);
        push_idle(2);
        for (int k = 0; k < 50; k++) q.push_back(2'b10);
        n = q.size();
        for (int i = 0; i < n; i++) begin
            e = q.pop_front();
            n_cmp++;
            if ({trigger, period_done} !== e) begin
                n_err++;
                $display("FAIL rst_mid[%0d] trig/pd: got %b want %b", i, {trigger, period_done}, e);
            end
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({trigger, period_done, active_high, cfg_ready} !== 11'b0) begin
            n_err++;
            $display("FAIL rst_mid_async: got %b want 0", {trigger, period_done, active_high, cfg_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({period_done, cfg_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_release: got %b want 00", {period_done, cfg_ready});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({trigger, period_done, cfg_ready} !== 3'b001) begin
                n_err++;
                $display("FAIL rst_mid_after[%0d] trig/pd/ready: got %b want 001", i, {trigger, period_done, cfg_ready});
            end
        end
        do_reset();
    endtask

    task automatic test_receiver();
        int   lq[$];
        int   hq[$];
        int   low_run = 0;
        int   high_run = 0;
        int   want;
        logic prev = 1'b0;
        bit   seen_high = 1'b0;
        for (int k = 0; k < 3; k++) lq.push_back(60);
        for (int k = 0; k < 4; k++) hq.push_back(40);
        en = 1'b1;
        offer(8'd40, 8'd60);
        for (int i = 0; i < 402; i++) begin
            if (trigger === 1'b1 && prev === 1'b0 && seen_high) begin
                want = (lq.size() > 0) ? lq.pop_front() : -1;
                n_cmp++;
                if (low_run !== want) begin
                    n_err++;
                    $display("FAIL receiver_low[%0d]: got %0d want %0d", i, low_run, want);
                end
                low_run = 0;
            end
            if (trigger === 1'b0 && prev === 1'b1) begin
                want = (hq.size() > 0) ? hq.pop_front() : -1;
                n_cmp++;
                if (high_run !== want) begin
                    n_err++;
                    $display("FAIL receiver_high[%0d]: got %0d want %0d", i, high_run, want);
                end
                high_run = 0;
            end
            if (trigger === 1'b1) begin high_run++; seen_high = 1'b1; end
            else if (seen_high) low_run++;
            prev = trigger;
            @(negedge clk);
        end
        n_cmp++;
        if (lq.size() + hq.size() != 0) begin
            n_err++;
            $display("FAIL receiver_runs: got %0d unmeasured want 0", lq.size() + hq.size());
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reconfig();
        test_degenerate();
        test_en_drop();
        test_long();
        test_rst_mid();
        test_receiver();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port en  input  1  run enable, sampled each clk.
REQ-004 SHALL have port cfg_valid  input  1  config offer, held with data until accepted.
REQ-005 SHALL have port cfg_ready  output  1  pending slot empty; accept occurs when cfg_valid && cfg_ready at a clk edge.
REQ-006 SHALL have port cfg_high  input  8  high-phase length in clk cycles.
REQ-007 SHALL have port cfg_low  input  8  low-phase length in clk cycles.
REQ-008 SHALL have port trigger  output  1  generated pulse train, registered, glitch-free.
REQ-009 SHALL have port period_done  output  1  one-cycle strobe on the last cycle of every period.
REQ-010 SHALL have port active_high  output  8  high length currently being generated.

Function
REQ-011 SHALL hold accepted config in a one-entry pending register; cfg_ready = !pending_valid, registered.
REQ-012 SHALL transfer pending to active only at a period boundary or on leaving IDLE, clearing pending_valid on the same edge.
REQ-013 SHALL implement states IDLE, HIGH, LOW; trigger = 1 only in HIGH.
REQ-014 IDLE -> HIGH (or LOW if high=0) when en=1 and pending_valid=1; load pending on that edge.
REQ-015 HIGH SHALL last exactly cfg_high cycles, then -> LOW; if low=0, end the period instead.
REQ-016 LOW SHALL last exactly cfg_low cycles, then end the period.
REQ-017 At period end: assert period_done; if en=0 -> IDLE; else reload pending if valid, otherwise repeat active; enter HIGH, or LOW if the new high=0.
REQ-018 high=0, low>0: trigger stays 0; period_done every low cycles.
REQ-019 high>0, low=0: trigger stays 1 continuously across periods; period_done every high cycles.
REQ-020 high=0 and low=0: config rejected at load; state -> IDLE; pending cleared; trigger 0.
REQ-021 en deassertion mid-period SHALL complete the current period, then -> IDLE.
REQ-022 Accept and pending transfer on the same edge: transfer the old pending, store the new config, pending_valid stays 1.
REQ-023 Phase counter SHALL be 8 bits, compared for equality against length-1, never wrapping past 255; length 255 yields 255 cycles.
REQ-024 Latency: after an accept while IDLE with en=1, trigger rises on the second clk edge after the accepting edge.
REQ-025 Pending SHALL NOT be overwritten while cfg_ready=0; an offer with cfg_ready=0 is ignored and must be held by the sender.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, trigger=0, period_done=0, active_high=0, pending_valid=0, and phase counter=0.
REQ-027 While rst=1, cfg_ready SHALL be 0; it SHALL become 1 on the first clk edge after rst deasserts.
REQ-028 rst mid-period SHALL abort immediately with no period_done strobe.

Structure
REQ-029 Package pulse_gen_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and the constant CNT_W = 8.
REQ-030 Sub-module pulse_cfg_stage SHALL implement the valid/ready pending register; the FSM and counter stay in pulse_gen.

Verification
REQ-031 Set high=3, low=5, en=1: trigger shows 3 high / 5 low cycles repeatedly; period_done every 8 cycles on the last LOW cycle.
REQ-032 Offer high=2, low=2 while running high=4, low=4: cfg_ready falls; new timing starts exactly at the next period boundary; cfg_ready rises the following cycle.
REQ-033 Apply high=0, low=6, then high=7, low=0, then 0/0: trigger constant 0, then constant 1, then IDLE with pending cleared.
REQ-034 Drop en at cycle 2 of a high=5, low=5 period: period completes (10 cycles), period_done fires, then IDLE with trigger 0.
REQ-035 Assert rst during HIGH at high=255: trigger 0 immediately, no period_done, cfg_ready 1 one edge after release.
REQ-036 Loop trigger into the counting receiver with high=40, low=60: received count equals the generated low length every period.
